sd_block_cache: RTL and testbench

Parametrised, write-back, direct-mapped multi-block cache between the CPU-side byte port and the SPI block controller of the SD card subsystem. It holds 2^LINE_BITS blocks of 512 bytes and serves byte reads and writes on hits. On a miss it evicts a dirty line and fills the requested block through the controller's streaming block interface. It also supports an explicit flush of all dirty lines and reports fill errors.

---
 rtl/sd_block_cache.sv | 201 ++++++++++++++++++++
 tb/tb_sd_block_cache.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_cache.sv
// sd_block_cache: write-back, direct-mapped cache of 512-byte SD blocks.
// Byte reads/writes are served from the data RAM on hits; misses evict a
// dirty victim through the controller's block-write stream and then refill
// the line through its block-read stream. An explicit flush writes back
// every dirty line in index order.
module sd_block_cache #(
    parameter int LINE_BITS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read,
    input  logic              write,
    input  logic [7:0]        wdata,
    input  logic              flush,
    output logic [7:0]        rdata,
    output logic              ready,
    output logic              err,
    output logic [ADDR_W-10:0] blk_addr,
    output logic              blk_rd,
    output logic              blk_wr,
    input  logic              blk_busy,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [8:0]        tx_index,
    output logic [7:0]        tx_data,
    output logic [7:0]        debug
);
    localparam int LINES = 1 << LINE_BITS;
    localparam int IDX_W = (LINE_BITS > 0) ? LINE_BITS : 1;
    localparam int BLK_W = ADDR_W - 9;
    localparam int TAG_W = ADDR_W - 9 - LINE_BITS;

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_EVICT, S_EVICT_WAIT, S_FILL,
        S_FILL_WAIT, S_ACCESS, S_FLUSH_SCAN, S_FLUSH_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              req_wr;
    logic [TAG_W-1:0]  tags [LINES];
    logic [LINES-1:0]  valid_bits, dirty_bits;
    logic [IDX_W-1:0]  line_cnt;
    logic [9:0]        fill_cnt;
    logic              busy_q;
    logic [7:0]        ram [LINES*512];

    logic [BLK_W-1:0]  req_blk, evict_blk, scan_blk;
    logic [IDX_W-1:0]  req_idx, wb_line;
    logic [TAG_W-1:0]  req_tag;
    logic [8:0]        req_byte;
    logic              busy_fall, hit, cur_dirty, scan_dirty, scan_last, fill_take;

    assign req_blk    = req_addr[ADDR_W-1:9];
    assign req_idx    = IDX_W'(req_blk & BLK_W'(LINES - 1));
    assign req_tag    = TAG_W'(req_blk >> LINE_BITS);
    assign req_byte   = req_addr[8:0];
    assign evict_blk  = (BLK_W'(tags[req_idx]) << LINE_BITS) | BLK_W'(req_idx);
    assign scan_blk   = (BLK_W'(tags[line_cnt]) << LINE_BITS) | BLK_W'(line_cnt);
    assign busy_fall  = busy_q & ~blk_busy;
    assign hit        = valid_bits[req_idx] && (tags[req_idx] == req_tag);
    assign cur_dirty  = dirty_bits[req_idx];
    assign scan_dirty = valid_bits[line_cnt] & dirty_bits[line_cnt];
    assign scan_last  = (line_cnt == IDX_W'(LINES - 1));
    // Bytes past the 512th of a fill are dropped.
    assign fill_take  = (state == S_FILL_WAIT) && rx_valid && (fill_cnt < 10'd512);
    // Write-back source line: the flush counter during flush, else the request line.
    assign wb_line    = (state == S_FLUSH_WAIT) ? line_cnt : req_idx;
    assign debug      = {state, hit, cur_dirty, blk_busy, ready};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and the ready handshake.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (write || read) state_nxt = S_LOOKUP;
                else if (flush)    state_nxt = S_FLUSH_SCAN;
            end
            S_LOOKUP: begin
                if (hit)                                        state_nxt = S_ACCESS;
                else if (valid_bits[req_idx] && cur_dirty)      state_nxt = S_EVICT;
                else                                            state_nxt = S_FILL;
            end
            S_EVICT:      state_nxt = S_EVICT_WAIT;
            S_EVICT_WAIT: if (busy_fall) state_nxt = S_FILL;
            S_FILL:       state_nxt = S_FILL_WAIT;
            S_FILL_WAIT: begin
                if (busy_fall) state_nxt = (fill_cnt == 10'd512) ? S_ACCESS : S_IDLE;
            end
            S_ACCESS:     state_nxt = S_IDLE;
            S_FLUSH_SCAN: begin
                if (scan_dirty)     state_nxt = S_FLUSH_WAIT;
                else if (scan_last) state_nxt = S_IDLE;
            end
            S_FLUSH_WAIT: begin
                if (busy_fall) state_nxt = scan_last ? S_IDLE : S_FLUSH_SCAN;
            end
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Request latch, line metadata, controller handshake and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wr     <= 1'b0;
            valid_bits <= '0;
            dirty_bits <= '0;
            for (int i = 0; i < LINES; i++) tags[i] <= '0;
            line_cnt   <= '0;
            fill_cnt   <= '0;
            busy_q     <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            blk_addr   <= '0;
            blk_rd     <= 1'b0;
            blk_wr     <= 1'b0;
            tx_data    <= '0;
        end else begin
            blk_rd  <= 1'b0;
            blk_wr  <= 1'b0;
            busy_q  <= blk_busy;
            tx_data <= ram[{wb_line, tx_index}];
            if (fill_take) fill_cnt <= fill_cnt + 10'd1;
            case (state)
                S_IDLE: begin
                    if (write || read) begin
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        req_wr    <= write;
                    end else if (flush) begin
                        line_cnt <= '0;
                    end
                end
                S_EVICT: begin
                    blk_addr <= evict_blk;
                    blk_wr   <= 1'b1;
                end
                S_EVICT_WAIT: if (busy_fall) dirty_bits[req_idx] <= 1'b0;
                S_FILL: begin
                    // The line is unusable until a complete fill lands.
                    blk_addr            <= req_blk;
                    blk_rd              <= 1'b1;
                    fill_cnt            <= '0;
                    valid_bits[req_idx] <= 1'b0;
                end
                S_FILL_WAIT: begin
                    if (busy_fall) begin
                        if (fill_cnt == 10'd512) begin
                            tags[req_idx]       <= req_tag;
                            valid_bits[req_idx] <= 1'b1;
                            dirty_bits[req_idx] <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (req_wr) dirty_bits[req_idx] <= 1'b1;
                    else        rdata <= ram[{req_idx, req_byte}];
                end
                S_FLUSH_SCAN: begin
                    if (scan_dirty) begin
                        blk_addr <= scan_blk;
                        blk_wr   <= 1'b1;
                    end else begin
                        line_cnt <= line_cnt + IDX_W'(1);
                    end
                end
                S_FLUSH_WAIT: begin
                    if (busy_fall) begin
                        dirty_bits[line_cnt] <= 1'b0;
                        line_cnt             <= line_cnt + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Data RAM writes: fill bytes stream in by index, CPU writes land in ACCESS.
    always_ff @(posedge clk) begin
        if (fill_take)
            ram[{req_idx, fill_cnt[8:0]}] <= rx_data;
        else if (state == S_ACCESS && req_wr)
            ram[{req_idx, req_byte}] <= req_wdata;
    end
endmodule

// File: tb/tb_sd_block_cache.sv
// Directed bench for sd_block_cache (LINE_BITS=2) with a small controller model.
module tb_sd_block_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0;
    logic        read = 1'b0, write = 1'b0, flush = 1'b0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ready, err;
    logic [22:0] blk_addr;
    logic        blk_rd, blk_wr;
    logic        blk_busy = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [8:0]  tx_index = '0;
    logic [7:0]  tx_data;
    logic [7:0]  debug;

    int n_checks = 0, n_fail = 0;
    int rd_pulses = 0, wr_pulses = 0;
    int rd0, wr0;

    sd_block_cache #(.LINE_BITS(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .read(read), .write(write),
        .wdata(wdata), .flush(flush), .rdata(rdata), .ready(ready), .err(err),
        .blk_addr(blk_addr), .blk_rd(blk_rd), .blk_wr(blk_wr), .blk_busy(blk_busy),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_index(tx_index),
        .tx_data(tx_data), .debug(debug)
    );

    always #5 clk = ~clk;

    // Count controller start pulses.
    always @(posedge clk) begin
        if (blk_rd) rd_pulses++;
        if (blk_wr) wr_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input bit r, input bit w, input bit f,
                           input logic [31:0] a, input logic [7:0] d);
        read = r; write = w; flush = f; addr = a; wdata = d;
        tick();
        read = 1'b0; write = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 3000) begin tick(); n++; end
        check({tag, " ready"}, 32'(ready), 32'd1);
    endtask

    // Wait for a start pulse, check its address and that it lasts one cycle.
    task automatic wait_pulse(input bit is_wr, input logic [22:0] exp_addr, input string tag);
        int n = 0;
        while (!(is_wr ? blk_wr : blk_rd) && n < 50) begin tick(); n++; end
        check({tag, " pulse"}, 32'(is_wr ? blk_wr : blk_rd), 32'd1);
        check({tag, " blk_addr"}, 32'(blk_addr), 32'(exp_addr));
        tick();
        check({tag, " pulse width"}, 32'(is_wr ? blk_wr : blk_rd), 32'd0);
    endtask

    // Controller read stream: nbytes of (index & 0xFF), then busy falls.
    task automatic serve_fill(input int nbytes);
        blk_busy = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        tick();
        blk_busy = 1'b0;
        tick();
    endtask

    // Controller write stream: probe one byte of the outgoing block.
    task automatic serve_wb(input logic [8:0] idx, input logic [7:0] exp, input string tag);
        blk_busy = 1'b1;
        tx_index = idx;
        tick();
        tick();
        check({tag, " tx_data"}, 32'(tx_data), 32'(exp));
        blk_busy = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst ready", 32'(ready), 1);
        check("rst rdata", 32'(rdata), 0);
        check("rst err", 32'(err), 0);
        check("rst blk_rd", 32'(blk_rd), 0);
        check("rst blk_wr", 32'(blk_wr), 0);
        check("rst blk_addr", 32'(blk_addr), 0);
        check("rst tx_data", 32'(tx_data), 0);
        check("rst debug", 32'(debug), 32'h01);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Cold read miss of block 1
        rd0 = rd_pulses;
        request(1, 0, 0, 32'h205, 8'h00);
        check("miss ready low", 32'(ready), 0);
        wait_pulse(0, 23'd1, "miss1 rd");
        serve_fill(512);
        wait_ready("miss1");
        check("miss1 rdata", 32'(rdata), 32'h05);
        check("miss1 rd count", 32'(rd_pulses - rd0), 1);

        // Hit read: ready exactly two cycles after acceptance
        rd0 = rd_pulses;
        request(1, 0, 0, 32'h206, 8'h00);
        check("hit lookup ready", 32'(ready), 0);
        tick();
        check("hit access ready", 32'(ready), 0);
        tick();
        check("hit done ready", 32'(ready), 1);
        check("hit rdata", 32'(rdata), 32'h06);
        check("hit no rd", 32'(rd_pulses - rd0), 0);

        // Dirty eviction: write hit then conflicting read of block 5
        request(0, 1, 0, 32'h205, 8'hAB);
        wait_ready("wr hit");
        request(1, 0, 0, 32'hA05, 8'h00);
        wait_pulse(1, 23'd1, "evict wr");
        serve_wb(9'd5, 8'hAB, "evict");
        wait_pulse(0, 23'd5, "evict rd");
        serve_fill(512);
        wait_ready("evict");
        check("evict rdata", 32'(rdata), 32'h05);

        // Dirty blocks 0 and 2, then flush writes both back in line order
        request(0, 1, 0, 32'h000, 8'h11);
        wait_pulse(0, 23'd0, "blk0 rd");
        serve_fill(512);
        wait_ready("blk0 wr");
        request(0, 1, 0, 32'h400, 8'h11);
        wait_pulse(0, 23'd2, "blk2 rd");
        serve_fill(512);
        wait_ready("blk2 wr");
        wr0 = wr_pulses;
        request(0, 0, 1, 32'h0, 8'h00);
        wait_pulse(1, 23'd0, "flush0");
        serve_wb(9'd0, 8'h11, "flush0");
        wait_pulse(1, 23'd2, "flush2");
        serve_wb(9'd0, 8'h11, "flush2");
        wait_ready("flush");
        check("flush wr count", 32'(wr_pulses - wr0), 2);

        // Clean flush: LINES+1 cycles, no write-back
        wr0 = wr_pulses;
        request(0, 0, 1, 32'h0, 8'h00);
        tick(); tick(); tick();
        check("flush2 busy", 32'(ready), 0);
        tick();
        check("flush2 ready", 32'(ready), 1);
        check("flush2 no wr", 32'(wr_pulses - wr0), 0);

        // Short fill: 300 bytes -> err, line stays invalid
        request(1, 0, 0, 32'h600, 8'h00);
        wait_pulse(0, 23'd3, "short rd");
        serve_fill(300);
        wait_ready("short");
        check("short err", 32'(err), 1);
        check("short rdata held", 32'(rdata), 32'h05);
        rd0 = rd_pulses;
        request(1, 0, 0, 32'h600, 8'h00);
        wait_pulse(0, 23'd3, "refill rd");
        serve_fill(512);
        wait_ready("refill");
        check("refill rd count", 32'(rd_pulses - rd0), 1);
        check("refill rdata", 32'(rdata), 32'h00);
        check("err sticky", 32'(err), 1);

        // read+write together: write wins, rdata unchanged
        rd0 = rd_pulses;
        request(1, 1, 0, 32'h10, 8'h5A);
        tick(); tick();
        check("rw ready", 32'(ready), 1);
        check("rw rdata held", 32'(rdata), 32'h00);
        check("rw no rd", 32'(rd_pulses - rd0), 0);
        request(1, 0, 0, 32'h10, 8'h00);
        wait_ready("rw readback");
        check("rw readback", 32'(rdata), 32'h5A);

        // Reset in the middle of a fill of block 6
        request(1, 0, 0, 32'hC00, 8'h00);
        wait_pulse(0, 23'd6, "abort rd");
        blk_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("abort ready", 32'(ready), 1);
        check("abort err", 32'(err), 0);
        check("abort rdata", 32'(rdata), 0);
        check("abort blk_addr", 32'(blk_addr), 0);
        check("abort tx_data", 32'(tx_data), 0);
        blk_busy = 1'b0; rx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd0 = rd_pulses;
        request(1, 0, 0, 32'hC07, 8'h00);
        wait_pulse(0, 23'd6, "post rst rd");
        serve_fill(512);
        wait_ready("post rst");
        check("post rst rd count", 32'(rd_pulses - rd0), 1);
        check("post rst rdata", 32'(rdata), 32'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
